// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings (HTRANS, HBURST, HRESP) and small helpers used by the
// arbiter slice. Other files import these rather than redefining them.
package ahb_arbiter_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // Beats remaining after the NONSEQ beat; undefined-length INCR counts as 0.
  function automatic logic [3:0] burst_last_beat(input logic [2:0] hburst);
    logic [3:0] beats;
    beats = 4'd0;
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:   beats = 4'd0;
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick3.sv
// Three-way round-robin selector: the search starts just after 'last' and wraps.
// Output is one-hot, or all zero when nobody is requesting.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so bit 0 is the highest-priority requester, pick lowest set bit, rotate back.
  always_comb begin
    rot  = req;
    pick = 3'b000;
    gnt  = 3'b000;
    case (last)
      2'd0:    rot = {req[0], req[2], req[1]};
      2'd1:    rot = {req[1], req[0], req[2]};
      default: rot = {req[2], req[1], req[0]};
    endcase
    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;
    case (last)
      2'd0:    gnt = {pick[1], pick[0], pick[2]};
      2'd1:    gnt = {pick[0], pick[2], pick[1]};
      default: gnt = pick;
    endcase
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Three-master AHB arbiter: registered one-hot grant, round-robin selection,
// burst and lock aware, with HMASTER/HMASTLOCK following grant on HREADY edges.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int NUM_MST     = 3,
  parameter int DEFAULT_MST = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  input  logic [1:0]         HRESP,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [1:0]         HMASTER,
  output logic               HMASTLOCK
);

  localparam logic [1:0]         DEF_IDX = DEFAULT_MST[1:0];
  localparam logic [NUM_MST-1:0] DEF_GNT = 3'b001 << DEFAULT_MST;

  logic [NUM_MST-1:0] grant_q;
  logic [NUM_MST-1:0] rr_gnt;
  logic [NUM_MST-1:0] grant_next;
  logic [1:0]         grant_idx;
  logic [1:0]         rr_last;
  logic [1:0]         hmaster_q;
  logic               mastlock_q;
  logic [3:0]         burst_cnt;
  logic [3:0]         burst_next;
  logic               resp_err;
  logic               lock_hold;
  logic               arbitrate;

  rr_pick3 u_pick (
    .req  (HBUSREQ),
    .last (rr_last),
    .gnt  (rr_gnt)
  );

  assign grant_idx  = onehot_to_idx(grant_q);
  assign lock_hold  = HLOCK[grant_idx];
  assign grant_next = (rr_gnt == '0) ? DEF_GNT : rr_gnt;

  // Arbitrating on the post-edge count lets the final beat hand over with no dead cycle.
  assign arbitrate  = HREADY && (burst_next == 4'd0) && !lock_hold;

  always_comb begin
    resp_err   = 1'b0;
    burst_next = burst_cnt;
    case (HRESP)
      HRESP_ERROR, HRESP_RETRY, HRESP_SPLIT: resp_err = 1'b1;
      HRESP_OKAY:                            resp_err = 1'b0;
      default:                               resp_err = 1'b0;
    endcase
    if (resp_err) begin
      burst_next = 4'd0;
    end else if (HREADY) begin
      case (HTRANS)
        TRANS_IDLE:   burst_next = 4'd0;
        TRANS_BUSY:   burst_next = burst_cnt;
        TRANS_NONSEQ: burst_next = burst_last_beat(HBURST);
        TRANS_SEQ:    burst_next = (burst_cnt == 4'd0) ? 4'd0 : burst_cnt - 4'd1;
        default:      burst_next = burst_cnt;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q <= DEF_GNT;
      rr_last <= DEF_IDX;
    end else if (arbitrate) begin
      grant_q <= grant_next;
      rr_last <= onehot_to_idx(grant_next);
    end
  end

  // Address-phase ownership only moves when the current transfer completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hmaster_q  <= DEF_IDX;
      mastlock_q <= 1'b0;
      burst_cnt  <= 4'd0;
    end else begin
      burst_cnt <= burst_next;
      if (HREADY) begin
        hmaster_q  <= grant_idx;
        mastlock_q <= HLOCK[grant_idx];
      end
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;

endmodule
